// File: rtl/adpll_pkg.sv
// adpll_pkg: shared definitions for the ADPLL capacitor-bank sequencer.
// Holds the sequencer state encoding, the power-up timing marks and the
// mid-code helper used to park banks that are not being acquired.
package adpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PU,
        ST_ACQ,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Power-up sequence marks, in cycles since entering PU.
    localparam int PU_TDC  = 16;  // TDC power-down released
    localparam int PU_INJ  = 32;  // TDC injection power-down released
    localparam int PU_DONE = 48;  // acquisition begins

    // Offset-binary zero for a BW-bit bank word.
    function automatic int unsigned mid_code(input int bw);
        return 32'd1 << (bw - 1);
    endfunction

endpackage

// File: rtl/adpll_lock_trk.sv
// adpll_lock_trk: two-candidate lock tracker for one bank acquisition.
// A candidate with count zero is empty and never matches. hit is
// combinational: it rises in the cycle whose sample brings a candidate to
// LOCK_N, so the owner can freeze that sample and clear the tracker at the
// same edge (clear has priority over the update).
module adpll_lock_trk
#(
    parameter int OTWW   = 13,
    parameter int LOCK_N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [OTWW-1:0] sample,
    output logic            hit
);
    localparam int CNTW = $clog2(LOCK_N + 1);

    logic [OTWW-1:0] v1, v2;
    logic [CNTW-1:0] c1, c2;
    logic            m1, m2;

    assign m1 = (c1 != '0) && (v1 == sample);
    assign m2 = (c2 != '0) && (v2 == sample);

    // Lock detect on the count the current sample would produce.
    always_comb begin
        if (m1)      hit = (c1 == CNTW'(LOCK_N - 1));
        else if (m2) hit = (c2 == CNTW'(LOCK_N - 1));
        else         hit = (LOCK_N == 1);
    end

    // Candidate update: bump a match, otherwise age candidate1 into slot 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= '0;
            v2 <= '0;
            c1 <= '0;
            c2 <= '0;
        end else if (en) begin
            if (clr) begin
                v1 <= '0;
                v2 <= '0;
                c1 <= '0;
                c2 <= '0;
            end else if (m1) begin
                c1 <= c1 + CNTW'(1);
            end else if (m2) begin
                c2 <= c2 + CNTW'(1);
            end else begin
                v2 <= v1;
                c2 <= c1;
                v1 <= sample;
                c1 <= CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/adpll_bank_seq.sv
// adpll_bank_seq: coarse-to-fine DCO capacitor bank acquisition sequencer.
// Powers up the DCO/TDC, then steers the saturated tuning word into one bank
// at a time until the lock tracker sees a stable value, freezes it, and moves
// to the next finer bank. The finest bank stays live through SETTLE/LOCKED.
// Optional macro ADPLL_LOCK_LOSS_EN: in LOCKED, four consecutive off-centre
// tuning words drop lock and restart acquisition on the second-finest bank.
module adpll_bank_seq
    import adpll_pkg::*;
#(
    parameter int NBANK      = 3,
    parameter int BW         = 8,
    parameter int OTWW       = 13,
    parameter int LOCK_N     = 8,
    parameter int SETTLE_CYC = 480,
    parameter int TMO_CYC    = 4095
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en,
    input  logic                                       start,
    input  logic [OTWW-1:0]                            otw,
    output logic [NBANK*BW-1:0]                        bank_word,
    output logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] active_bank,
    output logic                                       dco_pd,
    output logic                                       tdc_pd,
    output logic                                       tdc_pd_inj,
    output logic                                       rst_accum,
    output logic                                       channel_lock,
    output logic                                       cal_fail
);
    localparam int AW   = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CM1  = (TMO_CYC > SETTLE_CYC) ? TMO_CYC : SETTLE_CYC;
    localparam int CMAX = (CM1 > PU_DONE) ? CM1 : PU_DONE;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [BW-1:0]          MID     = BW'(mid_code(BW));
    localparam logic signed [OTWW-1:0] SAT_HI  = OTWW'(2**(BW-1) - 1);
    localparam logic signed [OTWW-1:0] SAT_LO  = OTWW'(-(2**(BW-1)));
    localparam logic [AW-1:0]          LAST    = AW'(NBANK - 1);
    localparam logic [AW-1:0]          LL_BANK = (NBANK > 1) ? AW'(NBANK - 2) : '0;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [NBANK-1:0][BW-1:0] frozen;
    logic signed [OTWW-1:0]  otw_s, sat_s;
    logic [BW-1:0]           live_word;
    logic                    live_st, hit, trk_clr;
    logic                    rst_acc_d, freeze, adv, enter_acq, ll_back;

    assign otw_s     = otw;
    assign live_word = {~sat_s[BW-1], sat_s[BW-2:0]};
    assign live_st   = (state == ST_ACQ) || (state == ST_SETTLE) || (state == ST_LOCKED);
    assign trk_clr   = (state != ST_ACQ) || !start || hit;

    // Clamp the tuning word to the signed range of one bank word.
    always_comb begin
        if (otw_s > SAT_HI)      sat_s = SAT_HI;
        else if (otw_s < SAT_LO) sat_s = SAT_LO;
        else                     sat_s = otw_s;
    end

    adpll_lock_trk #(.OTWW(OTWW), .LOCK_N(LOCK_N)) u_trk (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (trk_clr),
        .sample (sat_s),
        .hit    (hit)
    );

`ifdef ADPLL_LOCK_LOSS_EN
    localparam logic signed [OTWW-1:0] LL_HI = OTWW'(2**(BW-2));
    localparam logic signed [OTWW-1:0] LL_LO = OTWW'(-(2**(BW-2)));
    logic off_ctr;
    assign off_ctr = (otw_s > LL_HI) || (otw_s < LL_LO);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     state <= ST_IDLE;
        else if (en) state <= state_d;
    end

    // Next state, power-downs and datapath strobes; start=0 overrides all.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + CW'(1);
        rst_acc_d  = 1'b0;
        freeze     = 1'b0;
        adv        = 1'b0;
        enter_acq  = 1'b0;
        ll_back    = 1'b0;
        dco_pd     = 1'b0;
        tdc_pd     = 1'b0;
        tdc_pd_inj = 1'b0;
        case (state)
            ST_IDLE: begin
                dco_pd     = 1'b1;
                tdc_pd     = 1'b1;
                tdc_pd_inj = 1'b1;
                cnt_d      = '0;
                if (start) state_d = ST_PU;
            end
            ST_PU: begin
                tdc_pd     = (cnt < CW'(PU_TDC));
                tdc_pd_inj = (cnt < CW'(PU_INJ));
                // Transition on the last PU count so ACQ and the accumulator
                // clear both appear at count PU_DONE.
                if (cnt == CW'(PU_DONE - 1)) begin
                    state_d   = ST_ACQ;
                    cnt_d     = '0;
                    rst_acc_d = 1'b1;
                    enter_acq = 1'b1;
                end
            end
            ST_ACQ: begin
                if (hit) begin
                    freeze    = 1'b1;
                    rst_acc_d = 1'b1;
                    cnt_d     = '0;
                    if (active_bank == LAST) state_d = ST_SETTLE;
                    else                     adv     = 1'b1;
                end else if (cnt == CW'(TMO_CYC)) begin
                    state_d = ST_FAIL;
                    freeze  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt == CW'(SETTLE_CYC - 1)) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
`ifdef ADPLL_LOCK_LOSS_EN
                // cnt tracks consecutive off-centre samples here.
                if (off_ctr) begin
                    if (cnt == CW'(3)) begin
                        state_d   = ST_ACQ;
                        cnt_d     = '0;
                        rst_acc_d = 1'b1;
                        ll_back   = 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
`else
                cnt_d = '0;
`endif
            end
            ST_FAIL: cnt_d = '0;
            default: state_d = ST_IDLE;
        endcase
        if (!start) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            rst_acc_d = 1'b0;
            adv       = 1'b0;
            enter_acq = 1'b0;
            ll_back   = 1'b0;
            freeze    = live_st;
        end
    end

    // Counters, bank storage and active bank pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            active_bank <= '0;
            frozen      <= {NBANK{MID}};
        end else if (en) begin
            cnt <= cnt_d;
            if (enter_acq) begin
                frozen      <= {NBANK{MID}};
                active_bank <= '0;
            end
            if (freeze) frozen[active_bank] <= live_word;
            if (adv)    active_bank <= active_bank + AW'(1);
            if (ll_back) begin
                active_bank <= LL_BANK;
                for (int k = 0; k < NBANK; k++)
                    if (AW'(k) > LL_BANK) frozen[k] <= MID;
            end
        end
    end

    // Accumulator clear is a strict one-cycle pulse, even across en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_accum <= 1'b0;
        else     rst_accum <= en && rst_acc_d;
    end

    // Bank outputs: the active bank follows otw while live, others frozen.
    always_comb begin
        for (int k = 0; k < NBANK; k++)
            bank_word[k*BW +: BW] = (live_st && active_bank == AW'(k)) ? live_word : frozen[k];
    end

    assign channel_lock = (state == ST_LOCKED);
    assign cal_fail     = (state == ST_FAIL);

endmodule

// File: tb/tb_adpll_bank_seq.sv
// tb_adpll_bank_seq: directed tables, hand sequences and randomized traffic
// for adpll_bank_seq, checked each cycle against a behavioural model.
module tb_adpll_bank_seq;
    localparam int NB   = 3;
    localparam int BW   = 8;
    localparam int OTWW = 13;
    localparam int LN   = 8;
    localparam int SC   = 40;
    localparam int TMO  = 4095;

    localparam int P_IDLE = 0, P_PU = 1, P_ACQ = 2, P_SET = 3, P_LCK = 4, P_FAIL = 5;

    logic              clk = 1'b0;
    logic              rst, en, start;
    logic [OTWW-1:0]   otw;
    logic [NB*BW-1:0]  bank_word;
    logic [1:0]        active_bank;
    logic              dco_pd, tdc_pd, tdc_pd_inj, rst_accum, channel_lock, cal_fail;

    adpll_bank_seq #(.NBANK(NB), .BW(BW), .OTWW(OTWW), .LOCK_N(LN),
                     .SETTLE_CYC(SC), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .otw(otw),
        .bank_word(bank_word), .active_bank(active_bank),
        .dco_pd(dco_pd), .tdc_pd(tdc_pd), .tdc_pd_inj(tdc_pd_inj),
        .rst_accum(rst_accum), .channel_lock(channel_lock), .cal_fail(cal_fail)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // ---------------- behavioural model ----------------
    int ph, t, act, run, cur_o, m_racc;
    int fz[NB];
    int cv[2], cc[2];

    function automatic int sat(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int enc(input int s);
        return s + 128;
    endfunction

    task automatic trk_clear();
        cc[0] = 0; cc[1] = 0; cv[0] = 0; cv[1] = 0;
    endtask

    task automatic m_reset();
        ph = P_IDLE; t = 0; act = 0; run = 0; m_racc = 0;
        for (int k = 0; k < NB; k++) fz[k] = 128;
        trk_clear();
    endtask

    task automatic trk_push(input int s, output bit h);
        if (cc[0] > 0 && cv[0] == s)      cc[0]++;
        else if (cc[1] > 0 && cv[1] == s) cc[1]++;
        else begin
            cv[1] = cv[0]; cc[1] = cc[0];
            cv[0] = s;     cc[0] = 1;
        end
        h = (cc[0] >= LN) || (cc[1] >= LN);
        if (h) trk_clear();
    endtask

    task automatic m_step(input bit st, input int o, input bit e);
        int s; bit h;
        cur_o  = o;
        m_racc = 0;
        if (!e) return;
        s = sat(o);
        if (!st) begin
            if (ph == P_ACQ || ph == P_SET || ph == P_LCK) fz[act] = enc(s);
            ph = P_IDLE; t = 0; run = 0;
            return;
        end
        case (ph)
            P_IDLE: begin ph = P_PU; t = 0; end
            P_PU: begin
                if (t == 47) begin
                    ph = P_ACQ; t = 0; act = 0; m_racc = 1; trk_clear();
                    for (int k = 0; k < NB; k++) fz[k] = 128;
                end else t++;
            end
            P_ACQ: begin
                trk_push(s, h);
                if (h) begin
                    fz[act] = enc(s); m_racc = 1; t = 0;
                    if (act == NB - 1) ph = P_SET; else act++;
                end else if (t == TMO) begin
                    ph = P_FAIL; fz[act] = enc(s); t = 0;
                end else t++;
            end
            P_SET: begin
                if (t == SC - 1) begin ph = P_LCK; t = 0; run = 0; end
                else t++;
            end
            P_LCK: begin
`ifdef ADPLL_LOCK_LOSS_EN
                if (o > 64 || o < -64) begin
                    run++;
                    if (run == 4) begin
                        ph = P_ACQ; act = NB - 2; m_racc = 1; run = 0; t = 0;
                        trk_clear();
                        for (int k = NB - 1; k < NB; k++) fz[k] = 128;
                    end
                end else run = 0;
`endif
            end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NB*BW-1:0] ew;
        logic [2:0]       epd;
        bit               live;
        live = (ph == P_ACQ) || (ph == P_SET) || (ph == P_LCK);
        for (int k = 0; k < NB; k++)
            ew[k*BW +: BW] = BW'((live && act == k) ? enc(sat(cur_o)) : fz[k]);
        if (ph == P_IDLE)    epd = 3'b111;
        else if (ph == P_PU) epd = {1'b0, t < 16, t < 32};
        else                 epd = 3'b000;
        chk("bank_word",    64'(bank_word), 64'(ew));
        chk("active_bank",  64'(active_bank), 64'(act));
        chk("power_downs",  64'({dco_pd, tdc_pd, tdc_pd_inj}), 64'(epd));
        chk("rst_accum",    64'(rst_accum), 64'(m_racc));
        chk("channel_lock", 64'(channel_lock), 64'(ph == P_LCK));
        chk("cal_fail",     64'(cal_fail), 64'(ph == P_FAIL));
    endtask

    task automatic cyc(input bit st, input int o, input bit e = 1'b1);
        start = st; en = e; otw = OTWW'(o);
        m_step(st, o, e);
        @(posedge clk); #1;
        compare_all();
    endtask

    typedef struct { int o; logic [7:0] w; } sat_vec_t;
    sat_vec_t tv[12];

    initial begin
        int j, prev;
        tv[0]  = '{300,   8'hFF}; tv[1]  = '{-300,  8'h00}; tv[2]  = '{5,     8'h85};
        tv[3]  = '{127,   8'hFF}; tv[4]  = '{128,   8'hFF}; tv[5]  = '{-128,  8'h00};
        tv[6]  = '{-129,  8'h00}; tv[7]  = '{0,     8'h80}; tv[8]  = '{-1,    8'h7F};
        tv[9]  = '{4095,  8'hFF}; tv[10] = '{-4096, 8'h00}; tv[11] = '{64,    8'hC0};

        rst = 1'b1; en = 1'b1; start = 1'b0; otw = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pd",    64'({dco_pd, tdc_pd, tdc_pd_inj}), 64'(3'b111));
        chk("reset_words", 64'(bank_word), 64'(24'h808080));
        chk("reset_flags", 64'({rst_accum, channel_lock, cal_fail, active_bank}), 64'(0));
        rst = 1'b0;

        // Power-up timing with otw=5, continuing into bank-0 lock.
        for (int c = 1; c <= 49; c++) begin
            cyc(1'b1, 5);
            if (c == 1)  chk("dco_pd_c1",     64'(dco_pd), 64'(0));
            if (c == 16) chk("tdc_pd_c16",    64'(tdc_pd), 64'(1));
            if (c == 17) chk("tdc_pd_c17",    64'(tdc_pd), 64'(0));
            if (c == 32) chk("tdc_inj_c32",   64'(tdc_pd_inj), 64'(1));
            if (c == 33) chk("tdc_inj_c33",   64'(tdc_pd_inj), 64'(0));
            if (c == 48) chk("rst_accum_c48", 64'(rst_accum), 64'(0));
            if (c == 49) chk("rst_accum_c49", 64'(rst_accum), 64'(1));
        end
        for (int n = 1; n <= 8; n++) begin
            cyc(1'b1, 5);
            if (n == 7) chk("bank0_not_yet", 64'(active_bank), 64'(0));
            if (n == 8) begin
                chk("bank0_adv",    64'(active_bank), 64'(1));
                chk("bank0_frozen", 64'(bank_word[7:0]), 64'(8'h85));
            end
        end

        // Saturation table on bank 1.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, tv[i].o);
            chk("sat_table", 64'(bank_word[15:8]), 64'(tv[i].w));
        end

        // Alternating 3/4: candidate 3 reaches LOCK_N on the 15th sample.
        for (int n = 1; n <= 15; n++) begin
            cyc(1'b1, (n % 2) ? 3 : 4);
            if (n == 14) chk("alt_not_yet", 64'(active_bank), 64'(1));
            if (n == 15) begin
                chk("alt_adv",    64'(active_bank), 64'(2));
                chk("alt_frozen", 64'(bank_word[15:8]), 64'(8'h83));
            end
        end

        // Final bank lock, settle, locked.
        for (int n = 1; n <= 8; n++) begin
            cyc(1'b1, -300);
            if (n == 8) begin
                chk("b2_rst_accum", 64'(rst_accum), 64'(1));
                chk("b2_live_sat",  64'(bank_word[23:16]), 64'(8'h00));
                chk("b2_active",    64'(active_bank), 64'(2));
            end
        end
        for (int k = 1; k <= SC; k++) begin
            cyc(1'b1, -300);
            if (k == SC - 1) chk("settle_not_yet", 64'(channel_lock), 64'(0));
            if (k == SC)     chk("settle_lock",    64'(channel_lock), 64'(1));
        end

        // Off-centre tuning word in LOCKED.
        for (int n = 1; n <= 4; n++) begin
            cyc(1'b1, 100);
            if (n == 3) chk("ll_still_locked", 64'(channel_lock), 64'(1));
            if (n == 4) begin
`ifdef ADPLL_LOCK_LOSS_EN
                chk("ll_drop",   64'(channel_lock), 64'(0));
                chk("ll_bank",   64'(active_bank), 64'(NB - 2));
                chk("ll_accum",  64'(rst_accum), 64'(1));
`else
                chk("ll_sticky", 64'(channel_lock), 64'(1));
                chk("ll_bank",   64'(active_bank), 64'(2));
`endif
            end
        end
        cyc(1'b0, 100);
        chk("stop_pd",    64'({dco_pd, tdc_pd, tdc_pd_inj}), 64'(3'b111));
        chk("stop_flags", 64'({channel_lock, cal_fail}), 64'(0));
`ifdef ADPLL_LOCK_LOSS_EN
        chk("stop_kept",  64'(bank_word[23:8]), 64'(16'h80E4));
`else
        chk("stop_kept",  64'(bank_word[23:8]), 64'(16'hE483));
`endif

        // Timeout: a fresh value every cycle never locks.
        j = 0;
        for (int i = 0; i < 49; i++) begin cyc(1'b1, (j % 200) - 100); j++; end
        for (int i = 0; i < 4096; i++) begin
            cyc(1'b1, (j % 200) - 100); j++;
            if (i == 4094) chk("tmo_not_yet", 64'(cal_fail), 64'(0));
            if (i == 4095) begin
                chk("tmo_fail", 64'(cal_fail), 64'(1));
                chk("tmo_pd",   64'({dco_pd, tdc_pd, tdc_pd_inj}), 64'(3'b000));
            end
        end
        for (int i = 0; i < 3; i++) begin cyc(1'b1, (j % 200) - 100); j++; end
        cyc(1'b0, 0);
        chk("fail_clear", 64'(cal_fail), 64'(0));

        // Asynchronous reset in the middle of acquisition.
        for (int i = 0; i < 60; i++) cyc(1'b1, 2);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("arst_pd",    64'({dco_pd, tdc_pd, tdc_pd_inj}), 64'(3'b111));
        chk("arst_words", 64'(bank_word), 64'(24'h808080));
        chk("arst_flags", 64'({rst_accum, channel_lock, cal_fail, active_bank}), 64'(0));
        m_reset();
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic: sticky values so locks happen, rare stops,
        // occasional clock-enable gaps and wide excursions.
        prev = 0;
        for (int i = 0; i < 6000; i++) begin
            int r, o;
            r = int'($urandom_range(0, 99));
            if (r < 70)      o = prev;
            else if (r < 95) o = int'($urandom_range(0, 4)) - 2;
            else             o = int'($urandom_range(0, 8191)) - 4096;
            prev = o;
            cyc(($urandom_range(0, 399) != 0), o, ($urandom_range(0, 9) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
